// File: rtl/si5340_i2c_pkg.sv
// rtl/si5340_i2c_pkg.sv - shared types and constants for the Si5340 I2C target
package si5340_i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_MACK,
    ST_IGNORE
  } i2c_tgt_state_t;

  localparam logic [7:0] PAGE_REG_ADDR    = 8'h01;
  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h74;

endpackage

// File: rtl/i2c_target_line_filter.sv
// rtl/i2c_target_line_filter.sv - pad synchroniser, glitch filter and edge pulses for one I2C line
module i2c_target_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic pad_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   prev_q, prev_d;
  logic                   sample;

  assign sample = sync_q[SYNC_STAGES-1];

  // A new level is only accepted after FILTER_LEN consecutive differing samples.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pad_i};
    cnt_d   = '0;
    level_d = level_q;
    prev_d  = level_q;
    if (sample != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) level_d = sample;
      else                              cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      level_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= prev_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_q & ~prev_q;
  assign fall_o  = ~level_q & prev_q;

endmodule

// File: rtl/si5340_i2c_target.sv
// rtl/si5340_i2c_target.sv - I2C target exposing the Si5340 paged register map on a {page,reg} bus
module si5340_i2c_target
  import si5340_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 3
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        scl_pad_i,
  input  logic        sda_pad_i,
  output logic        sda_pad_o,
  output logic        sda_padoen_o,
  output logic        wr_en_o,
  output logic [15:0] wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic        rd_en_o,
  output logic [15:0] rd_addr_o,
  input  logic [7:0]  rd_data_i,
  output logic        busy_o
);

  logic scl, scl_rise, scl_fall, sda, sda_rise, sda_fall, start, stop;

  i2c_target_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk_i(clk_i), .arst_i(arst_i), .pad_i(scl_pad_i),
    .level_o(scl), .rise_o(scl_rise), .fall_o(scl_fall));

  i2c_target_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk_i(clk_i), .arst_i(arst_i), .pad_i(sda_pad_i),
    .level_o(sda), .rise_o(sda_rise), .fall_o(sda_fall));

  assign start = sda_fall & scl;
  assign stop  = sda_rise & scl;

  i2c_tgt_state_t state_q, state_d;
  logic [3:0]  bit_q, bit_d;
  logic [6:0]  shift_q, shift_d, tx_q, tx_d;
  logic [7:0]  ptr_q, ptr_d, page_q, page_d;
  logic        rw_q, rw_d, mack_q, mack_d, oe_q, oe_d, busy_q, busy_d;
  logic        wr_en_q, wr_en_d, rd_en_q, rd_en_d, rdpend_q, rdpend_d, lat_q, lat_d;
  logic [15:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  byte_in, ptr_inc, rbyte;

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    page_d    = page_q;
    rw_d      = rw_q;
    mack_d    = mack_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rdpend_d  = 1'b0;
    lat_d     = rdpend_q;
    byte_in   = {shift_q, sda};
    ptr_inc   = ptr_q + 8'd1;
    rbyte     = (ptr_q == PAGE_REG_ADDR) ? page_q : rd_data_i;

    if (start) begin
      state_d = ST_ADDR;
      bit_d   = '0;
      oe_d    = 1'b1;
      lat_d   = 1'b0;
    end else if (stop) begin
      state_d = ST_IDLE;
      bit_d   = '0;
      oe_d    = 1'b1;
      busy_d  = 1'b0;
      lat_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: if (scl_rise) begin
          shift_d = byte_in[6:0];
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd7) begin
            bit_d = '0;
            rw_d  = sda;
            // General call (0x00) never matches, even if DEV_ADDR were zero.
            if (byte_in[7:1] == DEV_ADDR && byte_in[7:1] != 7'd0) begin
              state_d = ST_ADDR_ACK;
              busy_d  = 1'b1;
            end else begin
              state_d = ST_IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        // First SCL fall starts driving the ACK, second one ends the 9th pulse.
        ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: if (scl_fall) begin
          if (bit_q == 4'd0) begin
            oe_d  = 1'b0;
            bit_d = 4'd1;
          end else begin
            oe_d  = 1'b1;
            bit_d = '0;
            if (state_q == ST_ADDR_ACK && rw_q) begin
              state_d   = ST_RDATA;
              rd_en_d   = (ptr_q != PAGE_REG_ADDR);
              rd_addr_d = {page_q, ptr_q};
              rdpend_d  = 1'b1;
            end else if (state_q == ST_ADDR_ACK) begin
              state_d = ST_REG;
            end else begin
              state_d = ST_WDATA;
            end
          end
        end
        ST_REG, ST_WDATA: if (scl_rise) begin
          shift_d = byte_in[6:0];
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd7) begin
            bit_d = '0;
            if (state_q == ST_REG) begin
              ptr_d   = byte_in;
              state_d = ST_REG_ACK;
            end else begin
              if (ptr_q == PAGE_REG_ADDR) begin
                page_d = byte_in;
              end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = {page_q, ptr_q};
                wr_data_d = byte_in;
              end
              ptr_d   = ptr_inc;
              state_d = ST_WDATA_ACK;
            end
          end
        end
        ST_RDATA: begin
          if (lat_q) begin
            tx_d = rbyte[6:0];
            oe_d = rbyte[7];
          end else if (scl_rise) begin
            bit_d = bit_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_q == 4'd8) begin
              oe_d    = 1'b1;
              bit_d   = '0;
              state_d = ST_RDATA_MACK;
            end else begin
              oe_d = tx_q[6];
              tx_d = {tx_q[5:0], 1'b0};
            end
          end
        end
        ST_RDATA_MACK: begin
          if (scl_rise) mack_d = ~sda;
          if (scl_fall) begin
            if (mack_q) begin
              ptr_d     = ptr_inc;
              rd_en_d   = (ptr_inc != PAGE_REG_ADDR);
              rd_addr_d = {page_q, ptr_inc};
              rdpend_d  = 1'b1;
              state_d   = ST_RDATA;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= ST_IDLE;
      bit_q     <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      page_q    <= '0;
      rw_q      <= 1'b0;
      mack_q    <= 1'b0;
      oe_q      <= 1'b1;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rdpend_q  <= 1'b0;
      lat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      page_q    <= page_d;
      rw_q      <= rw_d;
      mack_q    <= mack_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rdpend_q  <= rdpend_d;
      lat_q     <= lat_d;
    end
  end

  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = oe_q;
  assign busy_o       = busy_q;
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign rd_en_o      = rd_en_q;
  assign rd_addr_o    = rd_addr_q;

endmodule
